// File: rtl/button_event_scheduler_if.sv
// Event channel from the button scheduler to the mouse report logic: valid/ready with a button index.
interface button_event_scheduler_if #(
  parameter int ID_W = 3
);
  logic            o_event_valid;
  logic [ID_W-1:0] o_event_id;
  logic            i_event_ready;

  modport master (output o_event_valid, output o_event_id, input i_event_ready);
  modport slave  (input o_event_valid, input o_event_id, output i_event_ready);
endinterface

// File: rtl/button_event_scheduler.sv
// Per-button debounce/first-fire/auto-repeat sequencing, round-robin onto one event channel; fire->valid in 1 cycle,
// valid/id hold under backpressure, repeat fires land in a 1-deep pending slot. Auto-repeat enabled by BTN_AUTO_REPEAT_EN.
module button_event_scheduler #(
  parameter int NUM_BTN = 5,
  parameter int ID_W    = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_BTN-1:0]       i_button,
  input  logic [31:0]              i_debounce_max,
  input  logic [31:0]              i_repeat_delay,
  input  logic [31:0]              i_repeat_period,
  button_event_scheduler_if.master evt,
  output logic                     o_overflow,
  input  logic                     i_overflow_clr
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_DELAY,
    ST_REPEAT,
    ST_HELD
  } btn_state_t;

  btn_state_t         state     [NUM_BTN];
  btn_state_t         state_nxt [NUM_BTN];
  logic [31:0]        cnt       [NUM_BTN];
  logic [31:0]        cnt_nxt   [NUM_BTN];
  logic [NUM_BTN-1:0] fire;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] pending_nxt;
  logic [NUM_BTN-1:0] req;
  logic [NUM_BTN-1:0] granted;
  logic [NUM_BTN-1:0] drop;
  logic               event_valid;
  logic [ID_W-1:0]    event_id;
  logic [ID_W-1:0]    rr;
  logic [ID_W-1:0]    gidx;
  logic               grant;
  logic               can_grant;
  int                 best_d;
  int                 d;

`ifdef BTN_AUTO_REPEAT_EN
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{i_repeat_delay, i_repeat_period};
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i] <= ST_IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  // Release wins over a same-cycle fire, so a press one cycle short never emits.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      fire[i]      = 1'b0;
      if (!i_button[i]) begin
        state_nxt[i] = ST_IDLE;
        cnt_nxt[i]   = '0;
      end else begin
        case (state[i])
          ST_IDLE: begin
            state_nxt[i] = ST_DEBOUNCE;
            cnt_nxt[i]   = '0;
          end
          ST_DEBOUNCE: begin
            if (cnt[i] == i_debounce_max) begin
              fire[i]    = 1'b1;
              cnt_nxt[i] = '0;
`ifdef BTN_AUTO_REPEAT_EN
              state_nxt[i] = ST_DELAY;
`else
              state_nxt[i] = ST_HELD;
`endif
            end else begin
              cnt_nxt[i] = cnt[i] + 32'd1;
            end
          end
`ifdef BTN_AUTO_REPEAT_EN
          ST_DELAY: begin
            if (cnt[i] == i_repeat_delay) begin
              fire[i]      = 1'b1;
              cnt_nxt[i]   = '0;
              state_nxt[i] = ST_REPEAT;
            end else begin
              cnt_nxt[i] = cnt[i] + 32'd1;
            end
          end
          ST_REPEAT: begin
            if (cnt[i] == i_repeat_period) begin
              fire[i]    = 1'b1;
              cnt_nxt[i] = '0;
            end else begin
              cnt_nxt[i] = cnt[i] + 32'd1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Fresh fires compete directly so an idle channel shows the event on the next edge.
  always_comb begin
    req       = pending | fire;
    can_grant = !event_valid || evt.i_event_ready;
    grant     = can_grant && (|req);
    gidx      = '0;
    best_d    = NUM_BTN;
    d         = 0;
    for (int i = 0; i < NUM_BTN; i++) begin
      d = (i >= int'(rr)) ? (i - int'(rr)) : (i + NUM_BTN - int'(rr));
      if (req[i] && (d < best_d)) begin
        best_d = d;
        gidx   = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_BTN; i++) begin
      granted[i]     = grant && (gidx == ID_W'(i));
      pending_nxt[i] = granted[i] ? (pending[i] & fire[i]) : (pending[i] | fire[i]);
      drop[i]        = fire[i] & pending[i] & ~granted[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending     <= '0;
      event_valid <= 1'b0;
      event_id    <= '0;
      rr          <= '0;
      o_overflow  <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (grant) begin
        event_valid <= 1'b1;
        event_id    <= gidx;
        rr          <= (gidx == ID_W'(NUM_BTN - 1)) ? '0 : gidx + 1'b1;
      end else if (event_valid && evt.i_event_ready) begin
        event_valid <= 1'b0;
      end
      if (|drop) begin
        o_overflow <= 1'b1;
      end else if (i_overflow_clr) begin
        o_overflow <= 1'b0;
      end
    end
  end

  assign evt.o_event_valid = event_valid;
  assign evt.o_event_id    = event_id;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler: cycle table plus debounce, reset and repeat/hold sequences.
module tb_button_event_scheduler;
  localparam int NB = 5;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] button = '0;
  logic [31:0]   deb_max = 32'd2;
  logic [31:0]   rep_delay = 32'd1000;
  logic [31:0]   rep_period = 32'd1000;
  logic          ovf;
  logic          ovf_clr = 1'b0;
  int            n_tests = 0;
  int            n_fail = 0;

  button_event_scheduler_if #(.ID_W(IW)) evt ();

  button_event_scheduler #(.NUM_BTN(NB), .ID_W(IW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_button       (button),
    .i_debounce_max (deb_max),
    .i_repeat_delay (rep_delay),
    .i_repeat_period(rep_period),
    .evt            (evt),
    .o_overflow     (ovf),
    .i_overflow_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] b;
    logic          rdy;
    logic          clr;
    logic          ev;
    logic [IW-1:0] eid;
    logic          eo;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int n, input logic [NB-1:0] b, input logic rdy, input logic clr,
                              input logic ev, input logic [IW-1:0] eid, input logic eo);
    vec_t t;
    t.b = b; t.rdy = rdy; t.clr = clr; t.ev = ev; t.eid = eid; t.eo = eo;
    for (int k = 0; k < n; k++) vecs.push_back(t);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    button = '0;
    ovf_clr = 1'b0;
    evt.i_event_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  int            cnt_ev;
  int            first_k;
  int            times[$];
  int            exp_t[7] = '{5, 26, 32, 38, 44, 50, 56};
  logic          stable;

  initial begin
    // Table rows: inputs applied, one edge, then {valid,id,overflow} expected. Debounce = 2.
    add(1, 5'h00, 1, 0, 0, 0, 0);
    add(3, 5'h01, 1, 0, 0, 0, 0);          // one cycle short of firing
    add(2, 5'h00, 1, 0, 0, 0, 0);
    add(3, 5'h01, 1, 0, 0, 0, 0);
    add(1, 5'h01, 1, 0, 1, 0, 0);
    add(2, 5'h01, 1, 0, 0, 0, 0);
    add(1, 5'h00, 1, 0, 0, 0, 0);
    add(3, 5'h1A, 1, 0, 0, 0, 0);          // buttons 1,3,4 together
    add(1, 5'h1A, 1, 0, 1, 1, 0);
    add(1, 5'h1A, 1, 0, 1, 3, 0);
    add(1, 5'h1A, 1, 0, 1, 4, 0);
    add(1, 5'h1A, 1, 0, 0, 4, 0);
    add(1, 5'h00, 1, 0, 0, 4, 0);
    add(3, 5'h04, 1, 0, 0, 4, 0);          // button 2 moves rr to 3
    add(1, 5'h04, 1, 0, 1, 2, 0);
    add(1, 5'h04, 1, 0, 0, 2, 0);
    add(1, 5'h00, 1, 0, 0, 2, 0);
    add(3, 5'h12, 1, 0, 0, 2, 0);          // buttons 1,4 together: 4 first
    add(1, 5'h12, 1, 0, 1, 4, 0);
    add(1, 5'h12, 1, 0, 1, 1, 0);
    add(1, 5'h00, 1, 0, 0, 1, 0);
    add(3, 5'h01, 0, 0, 0, 1, 0);          // backpressure
    add(1, 5'h01, 0, 0, 1, 0, 0);
    add(1, 5'h01, 0, 0, 1, 0, 0);
    add(1, 5'h00, 0, 0, 1, 0, 0);
    add(3, 5'h01, 0, 0, 1, 0, 0);
    add(1, 5'h01, 0, 0, 1, 0, 0);          // queued in pending
    add(1, 5'h00, 0, 0, 1, 0, 0);
    add(3, 5'h01, 0, 0, 1, 0, 0);
    add(1, 5'h01, 0, 0, 1, 0, 1);          // dropped
    add(1, 5'h00, 1, 0, 1, 0, 1);          // back-to-back pending grant
    add(1, 5'h00, 1, 0, 0, 0, 1);
    add(1, 5'h00, 1, 1, 0, 0, 0);
    add(1, 5'h00, 1, 0, 0, 0, 0);
    add(3, 5'h01, 0, 0, 0, 0, 0);
    add(1, 5'h01, 0, 0, 1, 0, 0);
    add(1, 5'h00, 0, 0, 1, 0, 0);
    add(3, 5'h01, 0, 0, 1, 0, 0);
    add(1, 5'h01, 0, 0, 1, 0, 0);
    add(1, 5'h00, 0, 0, 1, 0, 0);
    add(3, 5'h01, 0, 0, 1, 0, 0);
    add(1, 5'h01, 0, 1, 1, 0, 1);          // drop beats clear
    add(1, 5'h00, 0, 1, 1, 0, 0);
    add(1, 5'h00, 1, 0, 1, 0, 0);
    add(1, 5'h00, 1, 0, 0, 0, 0);

    evt.i_event_ready = 1'b1;
    step();
    chk("reset_valid", int'(evt.o_event_valid), 0);
    chk("reset_id", int'(evt.o_event_id), 0);
    chk("reset_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    step();

    for (int r = 0; r < vecs.size(); r++) begin
      button = vecs[r].b;
      evt.i_event_ready = vecs[r].rdy;
      ovf_clr = vecs[r].clr;
      step();
      n_tests++;
      if ({evt.o_event_valid, evt.o_event_id, ovf} !== {vecs[r].ev, vecs[r].eid, vecs[r].eo}) begin
        n_fail++;
        $display("FAIL row%0d: got v=%0d id=%0d ovf=%0d, expected v=%0d id=%0d ovf=%0d", r,
                 evt.o_event_valid, evt.o_event_id, ovf, vecs[r].ev, vecs[r].eid, vecs[r].eo);
      end
    end

    // Debounce filter at 10 cycles.
    deb_max = 32'd10;
    do_reset();
    cnt_ev = 0;
    button = 5'h01;
    for (int k = 0; k < 8; k++) begin
      step();
      if (evt.o_event_valid) cnt_ev++;
    end
    button = '0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (evt.o_event_valid) cnt_ev++;
    end
    chk("short_press_events", cnt_ev, 0);
    button = 5'h01;
    step();
    cnt_ev = 0;
    first_k = -1;
    for (int k = 1; k <= 25; k++) begin
      if (k == 20) button = '0;
      step();
      if (evt.o_event_valid) begin
        cnt_ev++;
        if (first_k < 0) first_k = k;
      end
    end
    chk("debounce_events", cnt_ev, 1);
    chk("debounce_latency", first_k, 11);

    // Reset while an event is stalled.
    deb_max = 32'd3;
    do_reset();
    evt.i_event_ready = 1'b0;
    button = 5'h08;
    first_k = -1;
    for (int k = 0; k < 20 && first_k < 0; k++) begin
      step();
      if (evt.o_event_valid) first_k = k;
    end
    chk("pre_reset_valid", int'(evt.o_event_valid), 1);
    chk("pre_reset_id", int'(evt.o_event_id), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", int'(evt.o_event_valid), 0);
    chk("async_reset_id", int'(evt.o_event_id), 0);
    step();
    rst_n = 1'b1;
    step();
    first_k = -1;
    for (int k = 1; k <= 20 && first_k < 0; k++) begin
      step();
      if (evt.o_event_valid) first_k = k;
    end
    chk("post_reset_latency", first_k, 4);
    chk("post_reset_id", int'(evt.o_event_id), 3);

`ifdef BTN_AUTO_REPEAT_EN
    deb_max = 32'd4;
    rep_delay = 32'd20;
    rep_period = 32'd5;
    do_reset();
    button = 5'h04;
    step();
    times = {};
    for (int k = 1; k <= 62; k++) begin
      if (k == 60) button = '0;
      step();
      if (evt.o_event_valid) begin
        times.push_back(k);
        chk("repeat_id", int'(evt.o_event_id), 2);
      end
    end
    chk("repeat_count", times.size(), 7);
    for (int j = 0; j < 7; j++) chk("repeat_time", (j < times.size()) ? times[j] : -1, exp_t[j]);

    deb_max = 32'd0;
    rep_delay = 32'd3;
    rep_period = 32'd3;
    do_reset();
    evt.i_event_ready = 1'b0;
    button = 5'h01;
    step();
    step();
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!(evt.o_event_valid && evt.o_event_id == 0)) stable = 1'b0;
    end
    chk("bp_stable", int'(stable), 1);
    chk("bp_overflow", int'(ovf), 1);
    button = '0;
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("bp_ovf_cleared", int'(ovf), 0);
`else
    deb_max = 32'd4;
    do_reset();
    button = 5'h02;
    cnt_ev = 0;
    for (int k = 0; k < 210; k++) begin
      if (k == 200) button = '0;
      step();
      if (evt.o_event_valid) begin
        cnt_ev++;
        chk("held_id", int'(evt.o_event_id), 1);
      end
    end
    chk("held_events", cnt_ev, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
